// File: rtl/arena_access_arbiter.sv
// Arbitrates the arena cell RAM and VGA plot strobe among the initialiser, bomb controller and player.
// One transaction at a time: latch the winner, write (mirrored as a plot) or read after a fixed latency, then ack.
module arena_access_arbiter #(
    parameter logic [3:0] MAX_X     = 4'd11,
    parameter logic [3:0] MAX_Y     = 4'd9,
    parameter int         RD_LAT    = 2,
    parameter logic [2:0] WALL_CODE = 3'b010
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  req,
    input  logic [2:0]  req_wr,
    input  logic [11:0] req_x,
    input  logic [11:0] req_y,
    input  logic [8:0]  req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic [2:0]  rdata,
    output logic        addr_err,
    output logic        busy,
    output logic [3:0]  ram_x,
    output logic [3:0]  ram_y,
    output logic        ram_wren,
    output logic [2:0]  ram_wdata,
    input  logic [2:0]  ram_q,
    output logic [3:0]  vga_x,
    output logic [3:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        plot
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    // Handshake: a requester holds req[i] (and its fields) until it sees ack[i]; gnt[i] stays high from
    // the cycle after arbitration through the ack cycle; req[i] must be low in the cycle after ack[i].
    state_t      state_q, state_d;
    logic [1:0]  win_q, win_d, win_c;
    logic [3:0]  x_q, x_d, y_q, y_d;
    logic        wr_q, wr_d;
    logic [2:0]  wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  rdata_q, rdata_d;
    logic        ptr_q, ptr_d;      // 1 = requester 2 wins the next 1-vs-2 tie
    logic        in_range;
    logic [2:0]  win_oh;

    assign in_range = (x_q <= MAX_X) && (y_q <= MAX_Y);
    assign win_oh   = 3'b001 << win_q;

    always_comb begin
        win_c = 2'd2;
        if (req[0])                win_c = 2'd0;
        else if (req[1] && req[2]) win_c = ptr_q ? 2'd2 : 2'd1;
        else if (req[1])           win_c = 2'd1;
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        x_d     = x_q;
        y_d     = y_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    win_d = win_c;
                    err_d = 1'b0;
                    case (win_c)
                        2'd0: begin
                            x_d = req_x[3:0]; y_d = req_y[3:0];
                            wr_d = req_wr[0]; wdata_d = req_wdata[2:0];
                        end
                        2'd1: begin
                            x_d = req_x[7:4]; y_d = req_y[7:4];
                            wr_d = req_wr[1]; wdata_d = req_wdata[5:3];
                        end
                        default: begin
                            x_d = req_x[11:8]; y_d = req_y[11:8];
                            wr_d = req_wr[2]; wdata_d = req_wdata[8:6];
                        end
                    endcase
                    if (win_c != 2'd0) ptr_d = (win_c == 2'd1);
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!in_range) begin
                    err_d = 1'b1;
                    if (!wr_q) rdata_d = WALL_CODE;
                    state_d = S_DONE;
                end else if (wr_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = 3'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAT_LAST) begin
                    rdata_d = ram_q;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            win_q   <= 2'd0;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
            wr_q    <= 1'b0;
            wdata_q <= 3'd0;
            err_q   <= 1'b0;
            cnt_q   <= 3'd0;
            rdata_q <= 3'd0;
            ptr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ptr_q   <= ptr_d;
        end
    end

    // Outputs decode from the registered state so reset clears them without waiting for a clock.
    assign busy       = (state_q != S_IDLE);
    assign gnt        = busy ? win_oh : 3'b000;
    assign ack        = (state_q == S_DONE) ? win_oh : 3'b000;
    assign addr_err   = (state_q == S_DONE) && err_q;
    assign rdata      = rdata_q;
    assign ram_x      = x_q;
    assign ram_y      = y_q;
    assign ram_wren   = (state_q == S_ACCESS) && in_range && wr_q;
    assign ram_wdata  = wdata_q;
    assign plot       = ram_wren;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = wdata_q;

endmodule
